// File: rtl/mem_stage_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage_if : data-memory request/response bus between mem_stage and dmem
// Rev 1.0
// ---------------------------------------------------------------------------
interface mem_stage_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [AWIDTH-1:0] dmem_addr;
    logic [DWIDTH-1:0] dmem_wdata;
    logic [3:0]        dmem_be;
    logic              dmem_ready;
    logic              dmem_rvalid;
    logic [DWIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rvalid, dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage : RV32I memory-access stage; issues loads/stores, extends load
//             data and registers everything writeback consumes.
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] alu_res_i,
    input  logic [DWIDTH-1:0] rs2_data_i,
    input  logic              memren_i,
    input  logic              memwren_i,
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        wbsel_i,
    input  logic              brtaken_i,
    input  logic [4:0]        rd_i,
    input  logic              regwren_i,
    output logic              stall_o,
    mem_stage_if.master       dmem,
    output logic              valid_o,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] alu_res_o,
    output logic [DWIDTH-1:0] memory_data_o,
    output logic [1:0]        wbsel_o,
    output logic              brtaken_o,
    output logic [4:0]        rd_o,
    output logic              regwren_o,
    output logic              misalign_o
);
    typedef enum logic [0:0] {IDLE = 1'b0, WAIT_RSP = 1'b1} state_e;

    state_e            state_q;
    logic              valid_q, brtaken_q, regwren_q, misalign_q;
    logic [AWIDTH-1:0] pc_q;
    logic [DWIDTH-1:0] alu_res_q, memory_data_q;
    logic [1:0]        wbsel_q, ld_off_q;
    logic [4:0]        rd_q;
    logic [2:0]        ld_funct3_q;

    logic [1:0]        off;
    logic              mem_op, is_half, is_word, misalign, req;
    logic [3:0]        be;
    logic [DWIDTH-1:0] wdata;

    // funct3[1:0] encodes size for loads and stores alike: 00 byte, 01 half, else word
    assign off      = alu_res_i[1:0];
    assign mem_op   = memren_i | memwren_i;
    assign is_half  = (funct3_i[1:0] == 2'b01);
    assign is_word  = funct3_i[1];
    assign misalign = mem_op & ((is_half & off[0]) | (is_word & (off != 2'b00)));
    assign req      = (state_q == IDLE) & valid_i & mem_op & ~misalign;

    always_comb begin
        be    = 4'b0000;
        wdata = rs2_data_i;
        case (funct3_i[1:0])
            2'b00:   wdata = {4{rs2_data_i[7:0]}};
            2'b01:   wdata = {2{rs2_data_i[15:0]}};
            default: wdata = rs2_data_i;
        endcase
        if (req) begin
            if (memren_i) begin
                be = 4'b1111;
            end else begin
                case (funct3_i[1:0])
                    2'b00:   be = 4'b0001 << off;
                    2'b01:   be = 4'b0011 << off;
                    default: be = 4'b1111;
                endcase
            end
        end
    end

    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = req & ~memren_i;
    assign dmem.dmem_addr  = {alu_res_i[AWIDTH-1:2], 2'b00};
    assign dmem.dmem_wdata = wdata;
    assign dmem.dmem_be    = be;

    // A load always stalls its issue cycle; upstream only advances on the rvalid cycle
    always_comb begin
        stall_o = 1'b0;
        case (state_q)
            IDLE:     stall_o = req & (memren_i | ~dmem.dmem_ready);
            WAIT_RSP: stall_o = ~dmem.dmem_rvalid;
            default:  stall_o = 1'b0;
        endcase
    end

    function automatic logic [DWIDTH-1:0] load_extend(input logic [2:0]        f3,
                                                      input logic [1:0]        o,
                                                      input logic [DWIDTH-1:0] w);
        logic [DWIDTH-1:0] sh;
        sh = w >> {o, 3'b000};
        case (f3)
            3'b000:  return {{(DWIDTH-8){sh[7]}}, sh[7:0]};
            3'b100:  return {{(DWIDTH-8){1'b0}}, sh[7:0]};
            3'b001:  return {{(DWIDTH-16){sh[15]}}, sh[15:0]};
            3'b101:  return {{(DWIDTH-16){1'b0}}, sh[15:0]};
            default: return w;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            valid_q       <= 1'b0;
            pc_q          <= '0;
            alu_res_q     <= '0;
            memory_data_q <= '0;
            wbsel_q       <= '0;
            brtaken_q     <= 1'b0;
            rd_q          <= '0;
            regwren_q     <= 1'b0;
            misalign_q    <= 1'b0;
            ld_funct3_q   <= '0;
            ld_off_q      <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_i && (!mem_op || misalign || req && dmem.dmem_ready)) begin
                        pc_q          <= pc_i;
                        alu_res_q     <= alu_res_i;
                        memory_data_q <= '0;
                        wbsel_q       <= wbsel_i;
                        brtaken_q     <= brtaken_i;
                        rd_q          <= rd_i;
                        regwren_q     <= regwren_i & ~misalign;
                        misalign_q    <= misalign;
                        ld_funct3_q   <= funct3_i;
                        ld_off_q      <= off;
                        // An accepted load completes only when its response arrives
                        if (req && memren_i) begin
                            state_q <= WAIT_RSP;
                        end else begin
                            valid_q <= 1'b1;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (dmem.dmem_rvalid) begin
                        memory_data_q <= load_extend(ld_funct3_q, ld_off_q, dmem.dmem_rdata);
                        valid_q       <= 1'b1;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid_o       = valid_q;
    assign pc_o          = pc_q;
    assign alu_res_o     = alu_res_q;
    assign memory_data_o = memory_data_q;
    assign wbsel_o       = wbsel_q;
    assign brtaken_o     = brtaken_q;
    assign rd_o          = rd_q;
    assign regwren_o     = regwren_q;
    assign misalign_o    = misalign_q;
endmodule
`default_nettype wire
